// File: rtl/gcd_stein16.sv
// gcd_stein16 -- iterative binary (Stein) GCD engine.
//
// Each REDUCE iteration performs one subtract, then strips every factor of
// two from the difference in a single cycle via a trailing-zero counter.
//
// Ports:
//   clk_i    in   clock, rising edge
//   reset_i  in   synchronous active-high reset
//   a_i      in   operand A, sampled on input handshake
//   b_i      in   operand B, sampled on input handshake
//   valid_i  in   request valid
//   ready_o  out  engine idle and able to accept a request
//   gcd_o    out  result, meaningful while valid_o=1
//   valid_o  out  result valid
//   ready_i  in   consumer accepts result

// Trailing-zero counter: index of the lowest set bit of x.
// An all-zero input yields 0; callers never present one.
module gcd_stein16_tz #(
    parameter int W = 16
) (
    input  logic [W-1:0]         x,
    output logic [$clog2(W)-1:0] cnt
);
    localparam int CW = $clog2(W);

    // Scan from MSB down so the lowest set bit is the last one written.
    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (x[W-1-i]) cnt = CW'(W - 1 - i);
        end
    end
endmodule

module gcd_stein16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] gcd_o,
    output logic             valid_o,
    input  logic             ready_i
);
    localparam int KW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_INIT   = 2'd1;
    localparam logic [1:0] S_REDUCE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [KW-1:0]    k_r;
    logic [WIDTH-1:0] res_r;

    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] min_ab;
    logic [WIDTH-1:0] tz_b_in;
    logic [KW-1:0]    tz_a;
    logic [KW-1:0]    tz_b;

    // Both operands are odd in REDUCE, so diff is even and nonzero
    // whenever a_r != b_r.
    always_comb begin
        diff   = (a_r > b_r) ? (a_r - b_r) : (b_r - a_r);
        min_ab = (a_r < b_r) ? a_r : b_r;
    end

    // Second counter is shared: b_r during INIT, the difference in REDUCE.
    assign tz_b_in = (state == S_INIT) ? b_r : diff;

    gcd_stein16_tz #(.W(WIDTH)) u_tz_a (
        .x   (a_r),
        .cnt (tz_a)
    );

    gcd_stein16_tz #(.W(WIDTH)) u_tz_b (
        .x   (tz_b_in),
        .cnt (tz_b)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= S_IDLE;
            a_r   <= '0;
            b_r   <= '0;
            k_r   <= '0;
            res_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        a_r <= a_i;
                        b_r <= b_i;
                        if ((a_i == '0) || (b_i == '0)) begin
                            res_r <= a_i | b_i;
                            state <= S_DONE;
                        end else begin
                            state <= S_INIT;
                        end
                    end
                end
                S_INIT: begin
                    k_r   <= (tz_a < tz_b) ? tz_a : tz_b;
                    a_r   <= a_r >> tz_a;
                    b_r   <= b_r >> tz_b;
                    state <= S_REDUCE;
                end
                S_REDUCE: begin
                    if (a_r == b_r) begin
                        res_r <= a_r << k_r;
                        state <= S_DONE;
                    end else begin
                        a_r <= min_ab;
                        b_r <= diff >> tz_b;
                    end
                end
                default: begin
                    if (ready_i) state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o = (state == S_IDLE) && !reset_i;
    assign valid_o = (state == S_DONE);
    assign gcd_o   = res_r;
endmodule

// File: doc/gcd_stein16.md
# gcd_stein16

Iterative binary (Stein) GCD engine for unsigned WIDTH-bit operands. It sits directly downstream of the trailing-zero counter in the gcd block and instantiates two copies of it. Each REDUCE iteration does one subtract, then one trailing-zero count and shift. All factors of two are stripped in a single cycle, so no bit-serial shifting is needed. Requests arrive on a valid/ready input port, and the result leaves on a valid/ready output port.

## Interface
- WIDTH, 16: operand and result width. The trailing-zero counters are sized from it.

- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  reset, synchronous, active-high.
- a_i  in  WIDTH  operand A; sampled on input handshake.
- b_i  in  WIDTH  operand B; sampled on input handshake.
- valid_i  in  1  request valid.
- ready_o  out  1  engine idle and able to accept.
- gcd_o  out  WIDTH  result; valid only while valid_o=1.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.

## Operation
- Registers:
  - a_r and b_r, WIDTH bits each.
  - k_r, $clog2(WIDTH) bits: the common power-of-two exponent.
  - res_r, WIDTH bits.
  - state.
- States are IDLE, INIT, REDUCE and DONE.
- IDLE:
  - ready_o=1.
  - On valid_i & ready_o, latch a_i and b_i.
  - If either operand is 0, go to DONE with res_r = a_i | b_i. This gives gcd(0,x)=x and gcd(0,0)=0.
  - Otherwise go to INIT.
- INIT:
  - ta = tz(a_r) and tb = tz(b_r). Both operands are nonzero here.
  - k_r = min(ta, tb).
  - a_r = a_r >> ta and b_r = b_r >> tb, so both become odd.
  - Go to REDUCE.
- REDUCE (both operands odd, nonzero):
  - If a_r == b_r: res_r = a_r << k_r, then go to DONE. The shift cannot overflow, because the result is ≤ min(original operands).
  - Else: d = |a_r − b_r|, which is even and nonzero. Set a_r = min(a_r, b_r) and b_r = d >> tz(d). Stay in REDUCE.
- DONE:
  - valid_o=1 and gcd_o=res_r.
  - On ready_i, go to IDLE.
- The subtraction uses a WIDTH-bit unsigned compare and subtract. No carry beyond WIDTH is ever needed.
- One tz instance serves a_r in INIT. A second instance is shared between b_r in INIT and d in REDUCE.
- The tz all-zeros flag is never reached in INIT or REDUCE. An implementation may assert this.
- valid_i is ignored outside IDLE. No request is queued.

## Timing
- Reset:
  - While reset_i=1 at a clock edge, state goes to IDLE.
  - valid_o=0 and gcd_o=0.
  - ready_o=0 while reset_i is high, and 1 from the first cycle after release.
- Reset mid-operation (INIT, REDUCE or DONE) abandons the computation. No valid_o pulse is produced, and the next request computes correctly.
- Both outputs are registered-state decodes. There is no combinational path from valid_i or ready_i to ready_o or valid_o.
- Latency is counted from the accept cycle (cycle 0):
  - Zero-operand case: valid_o in cycle 1.
  - Otherwise: valid_o in cycle 2 + R, where R ≥ 1 is the number of REDUCE cycles, including the final equality cycle.
  - Worst case R ≤ 2·WIDTH.
- Back-to-back requests: the earliest next accept is the cycle after the output handshake.
  - Throughput is one result per (latency + 1) cycles with ready_i held at 1.
- Backpressure: while valid_o=1 and ready_i=0, gcd_o is held stable and ready_o stays 0.

## Test plan
- gcd(48,18):
  - INIT gives a=3, b=9, k=1.
  - REDUCE gives a=3, b=3, then equality.
  - Required: gcd_o=6 with valid_o in cycle 4 after accept.
- Zero operands:
  - gcd(0,35)=35, gcd(40,0)=40 and gcd(0,0)=0.
  - Each has valid_o in cycle 1 after accept.
- Powers of two and equal operands:
  - gcd(0x8000,0x4000)=0x4000 (k=14), valid_o in cycle 3.
  - gcd(0xFFFF,0xFFFF)=0xFFFF, valid_o in cycle 3.
- Long run: gcd(0xFFFF,1)=1 with latency ≤ 2+2·WIDTH. Compare a random sweep of 10k pairs against a reference model.
- Backpressure:
  - Hold ready_i=0 for 5 cycles after valid_o rises. Required: gcd_o stable, ready_o=0, and a valid_i pulse during this window is ignored.
  - Then raise ready_i. Required: ready_o=1 on the next cycle.
- Reset mid-REDUCE during gcd(0xFFFF,1):
  - Required: valid_o=0 after the reset edge, and ready_o=1 the cycle after release.
  - A following gcd(12,8) request must return 4.
